// File: rtl/muldiv_seq_r32i_pkg.sv
// Purpose: shared types, operation codes and decode helpers for the RV32M sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t, ITER_LAST, M-extension ALUCode values, is_mul_code/is_div_code/
//           is_signed_div/is_rem_code.
package muldiv_pkg_r32i;

   localparam int ITER_LAST = 31;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_FIXUP  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // ALUCode values mirrored from the execute-stage code table.
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;

   function automatic logic is_mul_code(input logic [4:0] code);
      return (code == ALU_MUL) || (code == ALU_MULH) ||
             (code == ALU_MULHSU) || (code == ALU_MULHU);
   endfunction

   function automatic logic is_div_code(input logic [4:0] code);
      return (code == ALU_DIV) || (code == ALU_DIVU) ||
             (code == ALU_REM) || (code == ALU_REMU);
   endfunction

   function automatic logic is_signed_div(input logic [4:0] code);
      return (code == ALU_DIV) || (code == ALU_REM);
   endfunction

   function automatic logic is_rem_code(input logic [4:0] code);
      return (code == ALU_REM) || (code == ALU_REMU);
   endfunction

endpackage

// File: rtl/muldiv_seq_r32i_if.sv
// Purpose: request/result handshake bundle between execute stage and M-unit sequencer.
// Latency: n/a (wires only).
// Backpressure: start_valid/start_ready on request side, result_valid/result_ready on result side.
// Signals: start_valid/start_ready, ALUCode, A, B, flush, result_valid/result_ready, result,
//          illegal, busy. master = requester, slave = sequencer.
interface muldiv_seq_r32i_if #(parameter int dataW = 32);

   logic             start_valid;
   logic             start_ready;
   logic [4:0]       ALUCode;
   logic [dataW-1:0] A;
   logic [dataW-1:0] B;
   logic             flush;
   logic             result_valid;
   logic             result_ready;
   logic [dataW-1:0] result;
   logic             illegal;
   logic             busy;

   modport master (
      output start_valid, ALUCode, A, B, flush, result_ready,
      input  start_ready, result_valid, result, illegal, busy
   );

   modport slave (
      input  start_valid, ALUCode, A, B, flush, result_ready,
      output start_ready, result_valid, result, illegal, busy
   );

endinterface

// File: rtl/muldiv_seq_r32i_div_step.sv
// Purpose: one combinational restoring-division step (shift in dividend bit, trial subtract).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the sequencer decides when the step result is registered.
// Ports: rem_in (partial remainder), divisor, bit_in (next dividend bit) -> rem_out, q_bit.
module div_step_r32i #(
   parameter int dataW = 32
) (
   input  logic [dataW:0]   rem_in,
   input  logic [dataW-1:0] divisor,
   input  logic             bit_in,
   output logic [dataW:0]   rem_out,
   output logic             q_bit
);

   logic [dataW+1:0] shifted;
   logic [dataW+1:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {2'b00, divisor};

   // A clear sign bit on the trial difference means the divisor fits.
   always_comb begin
      q_bit   = 1'b0;
      rem_out = shifted[dataW:0];
      if (!diff[dataW+1]) begin
         q_bit   = 1'b1;
         rem_out = diff[dataW:0];
      end
   end

endmodule

// File: rtl/muldiv_seq_r32i.sv
// Purpose: RV32M sequencer: single-cycle multiply, 32-iteration restoring divide/remainder.
// Latency: mul/special/illegal result_valid 1 cycle after accept; normal divide 34 cycles.
// Backpressure: start_ready only in IDLE; result held in DONE until result_ready; flush aborts.
// Ports: clock, reset (async, active-high), bus (muldiv_seq_r32i_if.slave).
module muldiv_seq_r32i
   import muldiv_pkg_r32i::*;
#(
   parameter int dataW = 32
) (
   input  logic               clock,
   input  logic               reset,
   muldiv_seq_r32i_if.slave   bus
);

   state_t           state_q, state_d;
   logic [4:0]       op_q;
   logic             a_neg_q, b_neg_q;
   logic [dataW-1:0] dvd_q;     // dividend shifts out the top, quotient shifts in the bottom
   logic [dataW-1:0] dvs_q;
   logic [dataW:0]   rem_q;
   logic [4:0]       cnt_q;
   logic [dataW-1:0] result_q;
   logic             illegal_q;

   logic             accept;
   logic             sdiv, a_sgn, b_sgn;
   logic [2*dataW-1:0] a_ext, b_ext, prod;
   logic [dataW-1:0] a_mag, b_mag;
   logic             ovf;
   logic [dataW-1:0] imm_res;
   logic             imm_ill;
   logic             to_div;
   logic [dataW:0]   rem_nxt;
   logic             q_bit;
   logic [dataW-1:0] fix_res;

   assign bus.start_ready  = (state_q == ST_IDLE);
   assign bus.result_valid = (state_q == ST_DONE);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.result       = result_q;
   assign bus.illegal      = illegal_q;

   // Flush wins over accept even in IDLE.
   assign accept = bus.start_valid && bus.start_ready && !bus.flush;

   // Multiplier: extend each operand to 64 bits per code; the low 64 bits of the
   // product are correct for every signedness mix.
   assign a_sgn = (bus.ALUCode == ALU_MUL) || (bus.ALUCode == ALU_MULH) ||
                  (bus.ALUCode == ALU_MULHSU);
   assign b_sgn = (bus.ALUCode == ALU_MUL) || (bus.ALUCode == ALU_MULH);
   assign a_ext = {{dataW{a_sgn & bus.A[dataW-1]}}, bus.A};
   assign b_ext = {{dataW{b_sgn & bus.B[dataW-1]}}, bus.B};
   assign prod  = a_ext * b_ext;

   assign sdiv  = is_signed_div(bus.ALUCode);
   assign a_mag = (sdiv && bus.A[dataW-1]) ? (~bus.A + 1'b1) : bus.A;
   assign b_mag = (sdiv && bus.B[dataW-1]) ? (~bus.B + 1'b1) : bus.B;
   assign ovf   = sdiv && (bus.A == {1'b1, {(dataW-1){1'b0}}}) && (&bus.B);

   // Results that are known at accept time and skip the divide loop.
   always_comb begin
      imm_res = '0;
      imm_ill = 1'b0;
      to_div  = 1'b0;
      if (is_mul_code(bus.ALUCode)) begin
         imm_res = (bus.ALUCode == ALU_MUL) ? prod[dataW-1:0] : prod[2*dataW-1:dataW];
      end else if (is_div_code(bus.ALUCode)) begin
         if (bus.B == '0)
            imm_res = is_rem_code(bus.ALUCode) ? bus.A : '1;
         else if (ovf)
            imm_res = is_rem_code(bus.ALUCode) ? '0 : bus.A;
         else
            to_div = 1'b1;
      end else begin
         imm_ill = 1'b1;
      end
   end

   div_step_r32i #(.dataW(dataW)) u_step (
      .rem_in  (rem_q),
      .divisor (dvs_q),
      .bit_in  (dvd_q[dataW-1]),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   // Sign restoration: quotient negative when signs differ, remainder follows the dividend.
   always_comb begin
      fix_res = '0;
      if (is_rem_code(op_q))
         fix_res = (is_signed_div(op_q) && a_neg_q) ? (~rem_q[dataW-1:0] + 1'b1)
                                                    : rem_q[dataW-1:0];
      else
         fix_res = (is_signed_div(op_q) && (a_neg_q ^ b_neg_q)) ? (~dvd_q + 1'b1) : dvd_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = to_div ? ST_DIVIDE : ST_DONE;
         ST_DIVIDE: if (cnt_q == 5'd0) state_d = ST_FIXUP;
         ST_FIXUP:  state_d = ST_DONE;
         ST_DONE:   if (bus.result_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (bus.flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         op_q      <= bus.ALUCode;
         a_neg_q   <= sdiv & bus.A[dataW-1];
         b_neg_q   <= sdiv & bus.B[dataW-1];
         dvd_q     <= a_mag;
         dvs_q     <= b_mag;
         rem_q     <= '0;
         cnt_q     <= 5'(ITER_LAST);
         illegal_q <= imm_ill;
         if (!to_div) result_q <= imm_res;
      end else if (state_q == ST_DIVIDE) begin
         rem_q <= rem_nxt;
         dvd_q <= {dvd_q[dataW-2:0], q_bit};
         if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
      end else if (state_q == ST_FIXUP) begin
         result_q <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_seq_r32i.sv
// Purpose: self-checking bench for muldiv_seq_r32i (vector table + scoreboard + corner sequences).
// Latency: n/a.
// Backpressure: exercises held results, flush aborts and mid-divide reset.
module tb_muldiv_seq_r32i;
   import muldiv_pkg_r32i::*;

   typedef struct {
      logic [4:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
   } exp_t;

   localparam int NVEC = 22;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   vec_t tbl [NVEC];
   exp_t sb [$];

   muldiv_seq_r32i_if #(.dataW(32)) bus ();

   muldiv_seq_r32i #(.dataW(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ill, input int lat);
      exp_t e;
      int   w = 0;
      while (!bus.start_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (w >= 100) check("start_ready_timeout", 32'd0, 32'd1);
      bus.ALUCode     = code;
      bus.A           = a;
      bus.B           = b;
      bus.start_valid = 1'b1;
      e.res = res; e.ill = ill; e.lat = lat;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      bus.start_valid = 1'b0;
      bus.A           = $urandom;
      bus.B           = $urandom;
      bus.ALUCode     = 5'($urandom);
   endtask

   // Waits for result_valid, pops scoreboard and compares; optionally completes handshake.
   task automatic collect(input string name, input bit handshake);
      exp_t e;
      int   lat = 1;
      while (!bus.result_valid && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({name, "_valid"}, 32'(bus.result_valid), 32'd1);
         check({name, "_result"}, bus.result, e.res);
         check({name, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
         check({name, "_latency"}, 32'(lat), 32'(e.lat));
      end
      if (handshake) begin
         bus.result_ready = 1'b1;
         @(posedge clock);
         @(negedge clock);
         bus.result_ready = 1'b0;
         check({name, "_valid_drop"}, 32'(bus.result_valid), 32'd0);
      end
   endtask

   initial begin
      int cnt;
      logic [31:0] held;

      tbl[0]  = '{ALU_MUL,    32'h00014C83, 32'hFFFE8BB0, 32'h1C69BB10, 1'b0, 1};
      tbl[1]  = '{ALU_MULH,   32'h00014C83, 32'hFFFE8BB0, 32'hFFFFFFFE, 1'b0, 1};
      tbl[2]  = '{ALU_MULHU,  32'h00014C83, 32'hFFFE8BB0, 32'h00014C81, 1'b0, 1};
      tbl[3]  = '{ALU_MULHSU, 32'h00014C83, 32'hFFFE8BB0, 32'h00014C81, 1'b0, 1};
      tbl[4]  = '{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
      tbl[5]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1};
      tbl[6]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1};
      tbl[7]  = '{ALU_DIV,    32'd18,       32'd4,        32'd4,        1'b0, 34};
      tbl[8]  = '{ALU_REM,    32'd18,       32'd4,        32'd2,        1'b0, 34};
      tbl[9]  = '{ALU_DIV,    32'd18,       32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 34};
      tbl[10] = '{ALU_REM,    32'd18,       32'hFFFFFFFC, 32'd2,        1'b0, 34};
      tbl[11] = '{ALU_DIV,    32'hFFFFFFEE, 32'd4,        32'hFFFFFFFC, 1'b0, 34};
      tbl[12] = '{ALU_REM,    32'hFFFFFFEE, 32'd4,        32'hFFFFFFFE, 1'b0, 34};
      tbl[13] = '{ALU_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
      tbl[14] = '{ALU_REMU,   32'd7,        32'd0,        32'd7,        1'b0, 1};
      tbl[15] = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
      tbl[16] = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
      tbl[17] = '{ALU_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34};
      tbl[18] = '{ALU_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34};
      tbl[19] = '{ALU_DIVU,   32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 1'b0, 34};
      tbl[20] = '{ALU_ADD,    32'd5,        32'd6,        32'h00000000, 1'b1, 1};
      tbl[21] = '{ALU_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 34};

      bus.start_valid  = 1'b0;
      bus.ALUCode      = '0;
      bus.A            = '0;
      bus.B            = '0;
      bus.flush        = 1'b0;
      bus.result_ready = 1'b0;

      // Reset values
      repeat (2) @(negedge clock);
      check("rst_start_ready", 32'(bus.start_ready), 32'd1);
      check("rst_result_valid", 32'(bus.result_valid), 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Vector table
      for (int i = 0; i < NVEC; i++) begin
         issue(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill, tbl[i].lat);
         collect($sformatf("vec%0d", i), 1'b1);
      end

      // Backpressure: hold result 5 cycles while a new request waits
      issue(ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 34);
      collect("bp_div", 1'b0);
      held = 32'd14;
      bus.ALUCode     = ALU_MUL;
      bus.A           = 32'd3;
      bus.B           = 32'd5;
      bus.start_valid = 1'b1;
      begin
         exp_t e;
         e.res = 32'd15; e.ill = 1'b0; e.lat = 1;
         sb.push_back(e);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check($sformatf("bp_hold_result%0d", c), bus.result, held);
         check($sformatf("bp_hold_valid%0d", c), 32'(bus.result_valid), 32'd1);
         check($sformatf("bp_hold_ready%0d", c), 32'(bus.start_ready), 32'd0);
      end
      bus.result_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.result_ready = 1'b0;
      check("bp_after_hs_ready", 32'(bus.start_ready), 32'd1);
      check("bp_after_hs_valid", 32'(bus.result_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      bus.start_valid = 1'b0;
      collect("bp_next", 1'b1);

      // Flush at cycle 10 of a divide
      bus.ALUCode     = ALU_DIV;
      bus.A           = 32'd1000;
      bus.B           = 32'd3;
      bus.start_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start_valid = 1'b0;
      repeat (9) @(negedge clock);
      check("flush_busy_before", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
      check("flush_busy_after", 32'(bus.busy), 32'd0);
      check("flush_start_ready", 32'(bus.start_ready), 32'd1);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (bus.result_valid) cnt++;
      end
      check("flush_no_result", 32'(cnt), 32'd0);

      // Flush in IDLE blocks accept
      bus.ALUCode     = ALU_MUL;
      bus.A           = 32'd2;
      bus.B           = 32'd2;
      bus.start_valid = 1'b1;
      bus.flush       = 1'b1;
      @(negedge clock);
      bus.start_valid = 1'b0;
      bus.flush       = 1'b0;
      check("flush_idle_busy", 32'(bus.busy), 32'd0);
      check("flush_idle_valid", 32'(bus.result_valid), 32'd0);

      // Reset mid-divide; result register holds 15 from the earlier multiply
      bus.ALUCode     = ALU_DIVU;
      bus.A           = 32'd5000;
      bus.B           = 32'd9;
      bus.start_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start_valid = 1'b0;
      repeat (5) @(negedge clock);
      check("rstmid_busy_before", 32'(bus.busy), 32'd1);
      check("rstmid_result_before", bus.result, 32'd15);
      reset = 1'b1;
      #1;
      check("rstmid_start_ready", 32'(bus.start_ready), 32'd1);
      check("rstmid_result_valid", 32'(bus.result_valid), 32'd0);
      check("rstmid_result", bus.result, 32'd0);
      check("rstmid_illegal", 32'(bus.illegal), 32'd0);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Recovery after reset
      issue(ALU_DIVU, 32'd5000, 32'd9, 32'd555, 1'b0, 34);
      collect("post_rst", 1'b1);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
